// File: rtl/ofmap_acc_buffer.sv
// ofmap_acc_buffer
//   Output-feature-map accumulation buffer at the bottom of the systolic array.
//   Each accepted row of MAC_COL partial sums is either written (first) or
//   added lane-wise into the entry it targets, through a 2-stage pipeline that
//   sustains one row per cycle with same-address forwarding. A hardware clear
//   sweep zeros every entry, and a registered test port reads entries back.
//
// Ports
//   clk, rst             clock; asynchronous active-high reset
//   clear_in             pulse: start clear sweep (taken only in IDLE)
//   clear_done_out       1-cycle pulse after the last clear write
//   acc_valid_in         partial-sum row valid
//   acc_ready_out        rows accepted (IDLE and no clear request)
//   acc_first_in         1: entry = data, 0: entry += data
//   acc_addr_in          target entry
//   acc_data_in          row data, lane i at [W*(i+1)-1:W*i]
//   busy_out             clearing, or a row still in the pipeline
//   err_out              sticky: out-of-range row address seen
//   test_check_in        test read enable
//   test_output_addr_in  test read address
//   test_output_out      test read data, one cycle after the request
module ofmap_acc_buffer #(
    parameter int MAC_COL        = 16,
    parameter int OFMAP_BITWIDTH = 32,
    parameter int OFMAP_ADDR_BIT = 10,
    parameter int OFMAP_NUM      = 784
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clear_in,
    output logic                              clear_done_out,
    input  logic                              acc_valid_in,
    output logic                              acc_ready_out,
    input  logic                              acc_first_in,
    input  logic [OFMAP_ADDR_BIT-1:0]         acc_addr_in,
    input  logic [MAC_COL*OFMAP_BITWIDTH-1:0] acc_data_in,
    output logic                              busy_out,
    output logic                              err_out,
    input  logic                              test_check_in,
    input  logic [OFMAP_ADDR_BIT-1:0]         test_output_addr_in,
    output logic [MAC_COL*OFMAP_BITWIDTH-1:0] test_output_out
);

    localparam int ROW_W = MAC_COL * OFMAP_BITWIDTH;
    localparam logic [OFMAP_ADDR_BIT-1:0] NUM_A  = OFMAP_ADDR_BIT'(OFMAP_NUM);
    localparam logic [OFMAP_ADDR_BIT-1:0] LAST_A = OFMAP_ADDR_BIT'(OFMAP_NUM - 1);

    typedef enum logic [0:0] {
        IDLE,
        CLEAR
    } state_t;

    state_t state, state_next;

    logic [ROW_W-1:0] mem [OFMAP_NUM];

    logic [OFMAP_ADDR_BIT-1:0] clr_addr;
    logic                      clr_last;

    // Stage 1: accepted row plus the old entry value it will be added to.
    logic                      s1_valid;
    logic                      s1_first;
    logic                      s1_in_range;
    logic [OFMAP_ADDR_BIT-1:0] s1_addr;
    logic [ROW_W-1:0]          s1_data;
    logic [ROW_W-1:0]          s1_old;
    logic [ROW_W-1:0]          s1_sum;

    logic accept;
    logic acc_in_range;
    logic test_in_range;
    logic forward;

    assign acc_ready_out = (state == IDLE) && !clear_in;
    assign accept        = acc_valid_in && acc_ready_out;
    assign acc_in_range  = acc_addr_in < NUM_A;
    assign test_in_range = test_output_addr_in < NUM_A;
    assign clr_last      = (clr_addr == LAST_A);
    assign busy_out      = (state != IDLE) || s1_valid;

    // The entry S1 is about to write is stale in memory this cycle, so a
    // back-to-back row to the same address takes S1's sum instead.
    assign forward = s1_valid && s1_in_range && (s1_addr == acc_addr_in);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every signal driven here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (clear_in) state_next = CLEAR;
            CLEAR:   if (clr_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Clear address counter and done pulse. The row in S1 (if any) writes on
    // the edge that enters CLEAR, so the sweep always starts on a drained pipe.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_addr       <= '0;
            clear_done_out <= 1'b0;
        end else begin
            clear_done_out <= (state == CLEAR) && clr_last;
            if (state == CLEAR && !clr_last) clr_addr <= clr_addr + 1'b1;
            else                             clr_addr <= '0;
        end
    end

    // ---------------- Accumulate pipeline ----------------
    always_comb begin
        s1_sum = '0;
        for (int i = 0; i < MAC_COL; i++) begin
            s1_sum[i*OFMAP_BITWIDTH +: OFMAP_BITWIDTH] =
                (s1_first ? '0 : s1_old[i*OFMAP_BITWIDTH +: OFMAP_BITWIDTH])
                + s1_data[i*OFMAP_BITWIDTH +: OFMAP_BITWIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_first    <= 1'b0;
            s1_in_range <= 1'b0;
            s1_addr     <= '0;
            s1_data     <= '0;
            s1_old      <= '0;
            err_out     <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_first    <= acc_first_in;
                s1_in_range <= acc_in_range;
                s1_addr     <= acc_addr_in;
                s1_data     <= acc_data_in;
                if (forward)           s1_old <= s1_sum;
                else if (acc_in_range) s1_old <= mem[acc_addr_in];
                else                   s1_old <= '0;
                if (!acc_in_range) err_out <= 1'b1;
            end
        end
    end

    // NOTE: the storage array has no reset; clear_in is the only way to zero it,
    // which keeps it mappable to RAM. State/S1 are reset, so no write fires
    // while rst is held.
    always_ff @(posedge clk) begin
        if (state == CLEAR)              mem[clr_addr] <= '0;
        else if (s1_valid && s1_in_range) mem[s1_addr] <= s1_sum;
    end

    // ---------------- Test readout ----------------
    // Reads see the pre-edge contents, so a same-edge write returns old data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            test_output_out <= '0;
        end else if (test_check_in) begin
            test_output_out <= test_in_range ? mem[test_output_addr_in] : '0;
        end
    end

endmodule

// File: tb/tb_ofmap_acc_buffer.sv
// tb_ofmap_acc_buffer
//   Randomized, scoreboard-checked bench for ofmap_acc_buffer. The reference
//   model is a plain array of entries updated immediately on each accepted row;
//   test reads push the model's value into a queue that a monitor drains one
//   cycle later when the registered read data appears.
module tb_ofmap_acc_buffer;

    localparam int MAC_COL = 16;
    localparam int W       = 32;
    localparam int AB      = 10;
    localparam int NUM     = 784;
    localparam int ROW_W   = MAC_COL * W;

    typedef logic [ROW_W-1:0] row_t;
    typedef struct {
        int   addr;
        row_t data;
    } rd_exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear_in;
    logic          clear_done_out;
    logic          acc_valid_in;
    logic          acc_ready_out;
    logic          acc_first_in;
    logic [AB-1:0] acc_addr_in;
    row_t          acc_data_in;
    logic          busy_out;
    logic          err_out;
    logic          test_check_in;
    logic [AB-1:0] test_output_addr_in;
    row_t          test_output_out;

    ofmap_acc_buffer #(
        .MAC_COL(MAC_COL), .OFMAP_BITWIDTH(W), .OFMAP_ADDR_BIT(AB), .OFMAP_NUM(NUM)
    ) dut (
        .clk(clk), .rst(rst),
        .clear_in(clear_in), .clear_done_out(clear_done_out),
        .acc_valid_in(acc_valid_in), .acc_ready_out(acc_ready_out),
        .acc_first_in(acc_first_in), .acc_addr_in(acc_addr_in), .acc_data_in(acc_data_in),
        .busy_out(busy_out), .err_out(err_out),
        .test_check_in(test_check_in), .test_output_addr_in(test_output_addr_in),
        .test_output_out(test_output_out)
    );

    always #5 clk = ~clk;

    row_t    model [NUM];
    rd_exp_t exp_q [$];
    row_t    last_read;
    int      n_tests = 0;
    int      n_fail  = 0;

    task automatic check(input string name, input row_t act, input row_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Lane-wise modular addition, as the accumulate rule states it.
    function automatic row_t model_acc(input row_t old, input row_t d, input bit first);
        row_t            r;
        longint unsigned s;
        for (int l = 0; l < MAC_COL; l++) begin
            s = (first ? 64'd0 : 64'(old[l*W +: W])) + 64'(d[l*W +: W]);
            r[l*W +: W] = 32'(s % (64'd1 << W));
        end
        return r;
    endfunction

    function automatic row_t splat(input logic [W-1:0] v);
        row_t r;
        for (int l = 0; l < MAC_COL; l++) r[l*W +: W] = v;
        return r;
    endfunction

    task automatic model_zero();
        for (int a = 0; a < NUM; a++) model[a] = '0;
    endtask

    // Monitor: a read requested before an edge is compared just after it.
    initial begin : monitor
        bit      rd;
        rd_exp_t e;
        forever begin
            @(posedge clk);
            rd = test_check_in && !rst;
            #1;
            if (rd) begin
                if (exp_q.size() == 0) begin
                    check("read_queue_nonempty", row_t'(exp_q.size()), row_t'(1));
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("read[%0d]", e.addr), test_output_out, e.data);
                end
            end
        end
    end

    // Called at a negedge; leaves the time at the next negedge.
    task automatic send_row(input int a, input bit f, input row_t d);
        acc_valid_in = 1'b1;
        acc_addr_in  = AB'(a);
        acc_first_in = f;
        acc_data_in  = d;
        #1;
        check("ready_idle", row_t'(acc_ready_out), row_t'(1));
        if (a < NUM) model[a] = model_acc(model[a], d, f);
        @(negedge clk);
        acc_valid_in = 1'b0;
    endtask

    task automatic read_one(input int a, input row_t exp);
        rd_exp_t e;
        test_check_in       = 1'b1;
        test_output_addr_in = AB'(a);
        e.addr = a;
        e.data = exp;
        exp_q.push_back(e);
        last_read = exp;
        @(negedge clk);
    endtask

    task automatic end_reads();
        test_check_in = 1'b0;
        repeat (2) @(negedge clk);
        check("read_hold", test_output_out, last_read);
    endtask

    task automatic sweep_model();
        for (int a = 0; a < NUM; a++) read_one(a, model[a]);
        end_reads();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_out && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_busy", row_t'(busy_out), row_t'(0));
    endtask

    // Called at a negedge. Returns the number of edges from the one that
    // samples clear_in up to and including the one raising clear_done_out.
    // stress: offer a row during CLEAR and pulse clear_in again mid-sweep.
    task automatic run_clear(input bit stress, output int cycles);
        int n    = 0;
        bit done = 1'b0;
        clear_in = 1'b1;
        while (!done && n < 4 * NUM) begin
            @(posedge clk);
            #1;
            n++;
            clear_in = 1'b0;
            if (stress) begin
                if (n == 3) begin
                    acc_valid_in = 1'b1;
                    acc_addr_in  = AB'(1);
                    acc_first_in = 1'b1;
                    acc_data_in  = '1;
                end
                if (n == 5) begin
                    check("ready_in_clear", row_t'(acc_ready_out), row_t'(0));
                    check("busy_in_clear", row_t'(busy_out), row_t'(1));
                end
                if (n == 7)  acc_valid_in = 1'b0;
                if (n == 10) clear_in = 1'b1;
            end
            if (clear_done_out) done = 1'b1;
        end
        cycles = n;
        @(posedge clk);
        #1;
        check("clear_done_pulse_width", row_t'(clear_done_out), row_t'(0));
        check("idle_after_clear", row_t'(busy_out), row_t'(0));
        @(negedge clk);
    endtask

    initial begin : main
        int   cyc;
        int   prev;
        int   a;
        bit   v;
        bit   f;
        row_t d;
        row_t e3;

        rst                 = 1'b1;
        clear_in            = 1'b0;
        acc_valid_in        = 1'b0;
        acc_first_in        = 1'b0;
        acc_addr_in         = '0;
        acc_data_in         = '0;
        test_check_in       = 1'b0;
        test_output_addr_in = '0;
        last_read           = '0;
        model_zero();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", row_t'(busy_out), row_t'(0));
        check("rst_err", row_t'(err_out), row_t'(0));
        check("rst_clear_done", row_t'(clear_done_out), row_t'(0));
        check("rst_test_out", test_output_out, '0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", row_t'(acc_ready_out), row_t'(1));

        // 1. Clear latency and all-zero sweep.
        run_clear(1'b0, cyc);
        check("clear_latency", row_t'(cyc), row_t'(NUM + 1));
        model_zero();
        sweep_model();

        // 2. Overwrite then back-to-back accumulate (forwarded operand).
        send_row(5, 1'b1, splat(32'd3));
        send_row(5, 1'b0, splat(32'd4));
        wait_idle();
        read_one(5, splat(32'd7));
        end_reads();

        // 3. Lane wrap-around, via memory (one idle cycle between rows).
        d = '0;
        e3 = '0;
        for (int l = 1; l < MAC_COL; l++) begin
            d[l*W +: W]  = 32'(l * 32'h1111);
            e3[l*W +: W] = 32'(l * 32'h1111);
        end
        d[W-1:0]  = 32'hFFFF_FFFF;
        e3[W-1:0] = 32'h0000_0001;
        send_row(10, 1'b1, d);
        @(negedge clk);
        d = '0;
        d[W-1:0] = 32'h2;
        send_row(10, 1'b0, d);
        wait_idle();
        read_one(10, e3);
        end_reads();

        // 4. Out-of-range row: sticky error, neighbours untouched.
        for (int l = 0; l < MAC_COL; l++) d[l*W +: W] = $urandom;
        send_row(NUM, 1'b0, d);
        check("err_set", row_t'(err_out), row_t'(1));
        repeat (5) @(negedge clk);
        check("err_sticky", row_t'(err_out), row_t'(1));
        read_one(NUM - 1, model[NUM-1]);
        read_one(0, model[0]);
        read_one(5, splat(32'd7));
        read_one(10, e3);
        end_reads();
        run_clear(1'b1, cyc);
        check("clear_latency_stress", row_t'(cyc), row_t'(NUM + 1));
        check("err_sticky_after_clear", row_t'(err_out), row_t'(1));
        model_zero();

        // 5. Random rows over 64 addresses, biased toward repeats.
        prev = 0;
        for (int k = 0; k < 600; k++) begin
            v = ($urandom_range(3) != 0);
            if ($urandom_range(2) == 0) a = prev;
            else                        a = int'($urandom_range(63));
            f = ($urandom_range(3) == 0);
            for (int l = 0; l < MAC_COL; l++) d[l*W +: W] = $urandom;
            if (v) begin
                send_row(a, f, d);
                prev = a;
            end else begin
                @(negedge clk);
            end
        end
        wait_idle();
        sweep_model();
        read_one(900, '0);
        read_one(10, model[10]);
        end_reads();

        // 6. Reset mid-clear, then a clean clear.
        clear_in = 1'b1;
        @(posedge clk);
        #1;
        clear_in = 1'b0;
        repeat (99) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_busy", row_t'(busy_out), row_t'(0));
        check("abort_err", row_t'(err_out), row_t'(0));
        check("abort_clear_done", row_t'(clear_done_out), row_t'(0));
        check("abort_test_out", test_output_out, '0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_idle_ready", row_t'(acc_ready_out), row_t'(1));
        check("abort_idle_busy", row_t'(busy_out), row_t'(0));
        run_clear(1'b0, cyc);
        check("clear_latency_after_abort", row_t'(cyc), row_t'(NUM + 1));
        model_zero();
        sweep_model();

        repeat (3) @(negedge clk);
        check("read_queue_drained", row_t'(exp_q.size()), row_t'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
